ntt_bf_sched: RTL and testbench



---
 rtl/ntt_sched_pkg.sv | 17 +
 rtl/bf_sched_dly.sv | 26 ++
 rtl/ntt_bf_sched.sv | 142 ++++++++++++++
 tb/tb_ntt_bf_sched.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ntt_sched_pkg.sv
// Shared butterfly-scheduler constants: FSM encoding, default pipeline depths, issue-to-writeback distance.
// Pure declarations, no latency or backpressure of its own.
package ntt_sched_pkg;

    localparam int RD_LAT_DEF = 1;
    localparam int BF_LAT_DEF = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int pipe_lat(input int rd_lat, input int bf_lat);
        return rd_lat + bf_lat;
    endfunction

endpackage

// File: rtl/bf_sched_dly.sv
// Fixed-depth shift register for {valid, addr_a, addr_b}; latency DEPTH cycles.
// No backpressure: shifts every cycle, async active-high clear.
module bf_sched_dly #(
    parameter int DEPTH = 11,
    parameter int W     = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] dat,
    output logic [W-1:0] dly_dat
);

    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= dat;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dly_dat = sr[DEPTH-1];

endmodule

// File: rtl/ntt_bf_sched.sv
// In-place DIF NTT issue/retire scheduler: reads issued one edge after RUN, write-back PIPE_LAT cycles later.
// Optional BF_SCHED_HOLD_EN adds a hold input that stalls issue in RUN while the delay line keeps draining.
module ntt_bf_sched
    import ntt_sched_pkg::*;
#(
    parameter int LOG_N  = 8,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int BF_LAT = BF_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inv,
`ifdef BF_SCHED_HOLD_EN
    input  logic             hold,
`endif
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-1:0] tw_addr,
    output logic             bf_sel,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b
);

    localparam int N        = 1 << LOG_N;
    localparam int PIPE_LAT = pipe_lat(RD_LAT, BF_LAT);
    localparam int JW       = LOG_N - 1;
    localparam int SW       = $clog2(LOG_N);
    localparam int CW       = $clog2(PIPE_LAT + 1);
    localparam int DW       = 1 + 2 * LOG_N;
    localparam logic [LOG_N-1:0] ONE = 1;

    logic [1:0]    state;
    logic [SW-1:0] s;
    logic [JW-1:0] j;
    logic [CW-1:0] cnt;
    logic          mode_r;
    logic          run_hold;

`ifdef BF_SCHED_HOLD_EN
    assign run_hold = hold;
`else
    assign run_hold = 1'b0;
`endif

    logic [LOG_N-1:0] j_ext, h_w, g_w, k_w, a_w, b_w;
    logic [LOG_N-2:0] twk_w;

    // Pair geometry: group stride is 2h, so g*2h reduces to a left shift by LOG_N-s.
    always_comb begin
        j_ext = {1'b0, j};
        h_w   = LOG_N'(N >> (int'(s) + 1));
        g_w   = j_ext >> (LOG_N - 1 - int'(s));
        k_w   = j_ext & (h_w - ONE);
        a_w   = (g_w << (LOG_N - int'(s))) | k_w;
        b_w   = a_w + h_w;
        twk_w = k_w[LOG_N-2:0] << s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            s         <= '0;
            j         <= '0;
            cnt       <= '0;
            mode_r    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            busy  <= (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r <= inv;
                        s      <= '0;
                        j      <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run_hold) begin
                        rd_en     <= 1'b1;
                        rd_addr_a <= a_w;
                        rd_addr_b <= b_w;
                        tw_addr   <= {mode_r, twk_w};
                        j         <= j + JW'(1);
                        if (j == '1) begin
                            cnt   <= CW'(PIPE_LAT);
                            state <= ST_DRAIN;
                        end
                    end
                end
                // Drain lasts exactly PIPE_LAT edges so the stage's last write lands just before the next stage's first read.
                ST_DRAIN: begin
                    if (cnt == CW'(1)) begin
                        if (int'(s) < LOG_N - 1) begin
                            s     <= s + SW'(1);
                            j     <= '0;
                            state <= ST_RUN;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bf_sel = mode_r;

    logic [DW-1:0] wb_dat;

    bf_sched_dly #(
        .DEPTH (PIPE_LAT),
        .W     (DW)
    ) u_dly (
        .clk     (clk),
        .rst     (rst),
        .dat     ({rd_en, rd_addr_a, rd_addr_b}),
        .dly_dat (wb_dat)
    );

    assign {wr_en, wr_addr_a, wr_addr_b} = wb_dat;

endmodule

// File: tb/tb_ntt_bf_sched.sv
// Directed bench for ntt_bf_sched at LOG_N=3 (PIPE_LAT=11); hold scenario built only with BF_SCHED_HOLD_EN.
module tb_ntt_bf_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       inv = 1'b0;
    logic       hold = 1'b0;
    logic       busy, done, rd_en, bf_sel, wr_en;
    logic [2:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;

    int checks = 0;
    int errors = 0;

    // Hand-derived pair table: stage 0, stage 1, stage 2, four pairs each.
    int exp_a  [12] = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
    int exp_b  [12] = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
    int exp_tw [12] = '{0, 1, 2, 3,  0, 2, 0, 2,  0, 0, 0, 0};

    always #5 clk = ~clk;

    ntt_bf_sched #(.LOG_N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inv       (inv),
`ifdef BF_SCHED_HOLD_EN
        .hold      (hold),
`endif
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .bf_sel    (bf_sel),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rd_idx(input int c);
        int st, i;
        if (c < 1) return -1;
        st = (c - 1) / 15;
        i  = (c - 1) % 15;
        if (st < 3 && i < 4) return st * 4 + i;
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " rd_en"}, rd_en, 0);
        chk({tag, " wr_en"}, wr_en, 0);
        chk({tag, " bf_sel"}, bf_sel, 0);
        chk({tag, " addrs"}, {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b}, 0);
    endtask

    // Issues start (edge = cycle 0) then checks every output for cycles 1..stop_c.
    task automatic run(input logic v, input int restart_c, input int stop_c);
        int idx, widx;
        start = 1'b1;
        inv   = v;
        tick();
        start = 1'b0;
        inv   = 1'b0;
        for (int c = 1; c <= stop_c; c++) begin
            if (c == restart_c) begin
                start = 1'b1;
                inv   = ~v;
            end
            tick();
            start = 1'b0;
            inv   = 1'b0;
            idx   = rd_idx(c);
            widx  = rd_idx(c - 11);
            chk($sformatf("rd_en c%0d", c), rd_en, idx >= 0);
            if (idx >= 0) begin
                chk($sformatf("rd_addr_a c%0d", c), rd_addr_a, exp_a[idx]);
                chk($sformatf("rd_addr_b c%0d", c), rd_addr_b, exp_b[idx]);
                chk($sformatf("tw_addr c%0d", c), tw_addr, v * 4 + exp_tw[idx]);
            end
            chk($sformatf("wr_en c%0d", c), wr_en, widx >= 0);
            if (widx >= 0) begin
                chk($sformatf("wr_addr_a c%0d", c), wr_addr_a, exp_a[widx]);
                chk($sformatf("wr_addr_b c%0d", c), wr_addr_b, exp_b[widx]);
            end
            chk($sformatf("done c%0d", c), done, c == 46);
            chk($sformatf("busy c%0d", c), busy, 1);
            chk($sformatf("bf_sel c%0d", c), bf_sel, v);
        end
    endtask

    initial begin
        // Reset state, even with start asserted.
        start = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk_all_zero("idle");

        // Forward run, then inverse run started the cycle after done with a stray start at cycle 10.
        run(1'b0, 0, 46);
        run(1'b1, 10, 46);
        tick();
        chk("post busy", busy, 0);
        chk("post done", done, 0);
        tick();
        chk("idle rd_en", rd_en, 0);
        chk("idle wr_en", wr_en, 0);

        // Reset in stage-1 drain: outputs clear at once and in-flight writes never retire.
        run(1'b1, 0, 25);
        rst = 1'b1;
        #1;
        chk_all_zero("mid reset");
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("post-rst wr_en %0d", c), wr_en, 0);
            chk($sformatf("post-rst rd_en %0d", c), rd_en, 0);
            chk($sformatf("post-rst busy %0d", c), busy, 0);
        end
        run(1'b0, 0, 46);
        tick();

`ifdef BF_SCHED_HOLD_EN
        // Hold sampled on edges 2..4: reads at 1,5,6,7; writes at 12,16,17,18; done at 49.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 49; c++) begin
            if (c == 2) hold = 1'b1;
            if (c == 5) hold = 1'b0;
            tick();
            if (c <= 18) begin
                chk($sformatf("hold rd_en c%0d", c), rd_en, c == 1 || (c >= 5 && c <= 7));
                chk($sformatf("hold wr_en c%0d", c), wr_en, c == 12 || (c >= 16 && c <= 18));
            end
            if (c == 5) begin
                chk("hold rd_addr_a c5", rd_addr_a, 1);
                chk("hold rd_addr_b c5", rd_addr_b, 5);
                chk("hold tw_addr c5", tw_addr, 1);
            end
            if (c == 16) chk("hold wr_addr_a c16", wr_addr_a, 1);
            chk($sformatf("hold done c%0d", c), done, c == 49);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
